// File: rtl/player_move_ctrl.sv
// Turns raw button levels into one-cycle step pulses, with a delayed auto-repeat
// for held buttons. Button inputs are synchronised, and opposing directions cancel.
module player_move_ctrl #(
  parameter int TICK_DIV    = 4,
  parameter int DELAY_TICKS = 3,
  parameter int RATE_TICKS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_up,
  input  logic       ctrl_down,
  input  logic       ctrl_left,
  input  logic       ctrl_right,
  input  logic       enable,
  output logic       step_up,
  output logic       step_down,
  output logic       step_left,
  output logic       step_right,
  output logic [1:0] state
);

  localparam int MAX_TICKS = (DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS;
  localparam int RW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int TW        = $clog2(TICK_DIV);

  localparam logic [RW-1:0] DELAY_LAST = RW'(DELAY_TICKS - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(RATE_TICKS - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Direction vectors use the bit order {up, down, left, right}.
  logic [3:0]    sync1, sync2, eff;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  state_t        state_q, state_d;
  logic [RW-1:0] rpt_cnt, rpt_d;
  logic [3:0]    last_dir, last_d;
  logic [3:0]    step_q, step_d;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ctrl_up, ctrl_down, ctrl_left, ctrl_right};
      sync2 <= sync1;
    end
  end

  assign eff = {sync2[3] & ~sync2[2], sync2[2] & ~sync2[3],
                sync2[1] & ~sync2[0], sync2[0] & ~sync2[1]};

  always_ff @(posedge clk) begin
    if (reset)             tick_cnt <= '0;
    else if (tick)         tick_cnt <= '0;
    else                   tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rpt_cnt  <= '0;
      last_dir <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      rpt_cnt  <= rpt_d;
      last_dir <= last_d;
      step_q   <= step_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_cnt;
    last_d  = last_dir;
    step_d  = '0;
    if (!enable) begin
      state_d = S_IDLE;
      rpt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (eff != '0) begin
            step_d  = eff;
            last_d  = eff;
            rpt_d   = '0;
            state_d = S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (eff == '0) begin
            state_d = S_IDLE;
            rpt_d   = '0;
          end else if (eff != last_dir) begin
            // A changed direction restarts the press and overrides any tick this cycle.
            step_d  = eff;
            last_d  = eff;
            rpt_d   = '0;
            state_d = S_DELAY;
          end else if (tick) begin
            if (rpt_cnt == ((state_q == S_DELAY) ? DELAY_LAST : RATE_LAST)) begin
              step_d  = last_dir;
              rpt_d   = '0;
              state_d = S_REPEAT;
            end else begin
              rpt_d = rpt_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          rpt_d   = '0;
        end
      endcase
    end
  end

  assign {step_up, step_down, step_left, step_right} = step_q;
  assign state = state_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl at TICK_DIV=4, DELAY_TICKS=3, RATE_TICKS=2.
// Inputs change and outputs are sampled on the falling edge; k counts rising edges since reset release.
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       up, down, left, right, enable;
  logic       step_up, step_down, step_left, step_right;
  logic [1:0] state;
  logic [3:0] stepv;

  int k;
  int total = 0;
  int bad   = 0;

  player_move_ctrl #(.TICK_DIV(4), .DELAY_TICKS(3), .RATE_TICKS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_up    (up),
    .ctrl_down  (down),
    .ctrl_left  (left),
    .ctrl_right (right),
    .enable     (enable),
    .step_up    (step_up),
    .step_down  (step_down),
    .step_left  (step_left),
    .step_right (step_right),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign stepv = {step_up, step_down, step_left, step_right};

  typedef struct {
    logic [3:0] btn;   // {up, down, left, right}
    logic       en;
    logic [3:0] exp;   // expected first step vector
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    {up, down, left, right} = 4'b0000;
    enable = 1'b1;
    reset  = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    k = 0;
  endtask

  // Per-cycle check of the step vector and state against hand-computed expectations.
  task automatic expect_cycle(input string tag, input logic [3:0] exp_step, input int exp_state);
    check($sformatf("%s step k=%0d", tag, k), int'(stepv), int'(exp_step));
    check($sformatf("%s state k=%0d", tag, k), int'(state), exp_state);
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 1'b1, 4'b1000};
    vecs[1]  = '{4'b0100, 1'b1, 4'b0100};
    vecs[2]  = '{4'b0010, 1'b1, 4'b0010};
    vecs[3]  = '{4'b0001, 1'b1, 4'b0001};
    vecs[4]  = '{4'b1001, 1'b1, 4'b1001};
    vecs[5]  = '{4'b0110, 1'b1, 4'b0110};
    vecs[6]  = '{4'b1100, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0011, 1'b1, 4'b0000};
    vecs[8]  = '{4'b1110, 1'b1, 4'b0010};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0000};
    vecs[10] = '{4'b1000, 1'b0, 4'b0000};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000};

    // Reset state.
    do_reset();
    check("reset step", int'(stepv), 0);
    check("reset state", int'(state), 0);

    // First-press table: pulse exactly 3 edges after the press, gone on the 4th.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      {up, down, left, right} = vecs[i].btn;
      enable = vecs[i].en;
      cyc();
      cyc();
      check($sformatf("vec%0d early", i), int'(stepv), 0);
      cyc();
      check($sformatf("vec%0d step", i), int'(stepv), int'(vecs[i].exp));
      check($sformatf("vec%0d state", i), int'(state), (vecs[i].exp != 4'b0000) ? 1 : 0);
      cyc();
      check($sformatf("vec%0d one-shot", i), int'(stepv), 0);
    end

    // Held up: pulses at 3, 12, then every 8 cycles.
    do_reset();
    up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      expect_cycle("hold_up",
                   (k == 3 || k == 12 || (k > 12 && (k - 12) % 8 == 0)) ? 4'b1000 : 4'b0000,
                   (k < 3) ? 0 : (k < 12) ? 1 : 2);
    end

    // Up and down cancel; releasing down gives a fresh press.
    do_reset();
    up = 1'b1;
    down = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      expect_cycle("up_down", 4'b0000, 0);
    end
    down = 1'b0;
    for (int i = 21; i <= 24; i++) begin
      cyc();
      expect_cycle("release_down", (k == 23) ? 4'b1000 : 4'b0000, (k >= 23) ? 1 : 0);
    end

    // Add right during REPEAT: immediate diagonal pulse, delay restarts.
    do_reset();
    up = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      expect_cycle("diag",
                   (k == 3 || k == 12) ? 4'b1000 : (k == 17 || k == 28) ? 4'b1001 : 4'b0000,
                   (k < 3) ? 0 : (k < 12) ? 1 : (k < 17) ? 2 : (k < 28) ? 1 : 2);
      if (k == 14) right = 1'b1;
    end

    // Release during DELAY, then a tap shorter than one tick.
    do_reset();
    up = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      expect_cycle("release_tap",
                   (k == 3) ? 4'b1000 : (k == 19) ? 4'b0010 : 4'b0000,
                   ((k >= 3 && k <= 7) || k == 19) ? 1 : 0);
      if (k == 5)  up = 1'b0;
      if (k == 16) left = 1'b1;
      if (k == 17) left = 1'b0;
    end

    // Enable dropped for 5 cycles while holding left.
    do_reset();
    left = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      expect_cycle("enable_drop",
                   (k == 3 || k == 12 || k == 24 || k == 36) ? 4'b0010 : 4'b0000,
                   (k < 3) ? 0 : (k < 12) ? 1 : (k < 19) ? 2 : (k < 24) ? 0 : (k < 36) ? 1 : 2);
      if (k == 18) enable = 1'b0;
      if (k == 23) enable = 1'b1;
    end

    // Reset mid-REPEAT suppresses the pulse due at edge 20; a held button restarts as a new press.
    do_reset();
    left = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      cyc();
      expect_cycle("pre_reset", (k == 3 || k == 12) ? 4'b0010 : 4'b0000,
                   (k < 3) ? 0 : (k < 12) ? 1 : 2);
    end
    reset = 1'b1;
    cyc();
    expect_cycle("in_reset", 4'b0000, 0);
    cyc();
    expect_cycle("in_reset", 4'b0000, 0);
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      expect_cycle("post_reset", (k == 3) ? 4'b0010 : 4'b0000, (k >= 3) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
